// File: rtl/ser8_seq_pkg.sv
// Shared types and constants for the 8-bit parallel-to-serial sequencer.
package ser8_seq_pkg;

  localparam int unsigned SEL_W  = 3;
  localparam int unsigned WORD_W = 8;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

  // Index of the first bit sent for a word.
  function automatic logic [SEL_W-1:0] start_idx(input bit lsb_first);
    return lsb_first ? 3'd0 : 3'd7;
  endfunction

  // Index of the final bit sent for a word.
  function automatic logic [SEL_W-1:0] end_idx(input bit lsb_first);
    return lsb_first ? 3'd7 : 3'd0;
  endfunction

endpackage

// File: rtl/ser8_sel_ctr.sv
// Bit-index counter: restarts at the start index, steps towards the end index.
module ser8_sel_ctr
  import ser8_seq_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  output logic [SEL_W-1:0] sel,
  output logic             at_end
);

  logic [SEL_W-1:0] sel_q, sel_d;

  // Next index: restart wins over step; never steps past the end index.
  always_comb begin
    sel_d = sel_q;
    if (load) begin
      sel_d = start_idx(LSB_FIRST);
    end else if (step && !at_end) begin
      sel_d = LSB_FIRST ? (sel_q + 3'd1) : (sel_q - 3'd1);
    end
  end

  // Index register with synchronous reset to the start index.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= start_idx(LSB_FIRST);
    end else begin
      sel_q <= sel_d;
    end
  end

  assign sel    = sel_q;
  assign at_end = (sel_q == end_idx(LSB_FIRST));

endmodule

// File: rtl/ser8_seq.sv
// Holds a parallel word and walks a downstream 8:1 mux select across it,
// one bit per accepted handshake, with zero-bubble back-to-back loading.
module ser8_seq
  import ser8_seq_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] d,
  output logic [SEL_W-1:0]  sel,
  output logic              bit_valid,
  output logic              bit_out,
  input  logic              bit_ready,
  output logic              last,
  output logic              done
);

  state_e            state_q;
  logic [WORD_W-1:0] d_q;
  logic              done_q;
  logic              at_end;
  logic              load_xfer;
  logic              bit_xfer;
  logic              final_xfer;
  logic              ctr_load;
  logic              ctr_step;

  // Handshake decode; a new word is accepted in idle or alongside the final bit.
  always_comb begin
    bit_valid  = (state_q == StShift);
    last       = bit_valid && at_end;
    load_ready = !rst && (!bit_valid || (last && bit_ready));
    load_xfer  = load_valid && load_ready;
    bit_xfer   = bit_valid && bit_ready;
    final_xfer = bit_xfer && last;
    // Restart the index after the final bit too, so idle shows the start index.
    ctr_load   = load_xfer || final_xfer;
    ctr_step   = bit_xfer && !last;
  end

  ser8_sel_ctr #(
    .LSB_FIRST(LSB_FIRST)
  ) u_sel_ctr (
    .clk   (clk),
    .rst   (rst),
    .load  (ctr_load),
    .step  (ctr_step),
    .sel   (sel),
    .at_end(at_end)
  );

  // Control FSM with the held word and the registered done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      d_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= final_xfer;
      if (load_xfer) begin
        d_q     <= load_data;
        state_q <= StShift;
      end else if (final_xfer) begin
        state_q <= StIdle;
      end
    end
  end

  assign d       = d_q;
  assign done    = done_q;
  assign bit_out = d_q[sel];

endmodule

// File: tb/tb_ser8_seq.sv
// Self-checking bench: LSB-first and MSB-first instances share all inputs.
module tb_ser8_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic [7:0] load_data;
  logic       bit_ready;

  logic       lr_l, bv_l, bo_l, last_l, done_l;
  logic [7:0] d_l;
  logic [2:0] sel_l;
  logic       lr_m, bv_m, bo_m, last_m, done_m;
  logic [7:0] d_m;
  logic [2:0] sel_m;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: word in flight, bits already sent, pending done.
  logic       m_busy;
  int         m_k;
  logic [7:0] m_word;
  logic       m_done;

  always #5 clk = ~clk;

  ser8_seq #(.LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(lr_l), .load_data(load_data),
    .d(d_l), .sel(sel_l), .bit_valid(bv_l), .bit_out(bo_l), .bit_ready(bit_ready),
    .last(last_l), .done(done_l)
  );

  ser8_seq #(.LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(lr_m), .load_data(load_data),
    .d(d_m), .sel(sel_m), .bit_valid(bv_m), .bit_out(bo_m), .bit_ready(bit_ready),
    .last(last_m), .done(done_m)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic m_lr();
    return !rst && (!m_busy || (m_k == 7 && bit_ready));
  endfunction

  // Compare every output of both instances against the model.
  task automatic model_check();
    int          sl, sm;
    logic [7:0]  w;
    sl = m_busy ? m_k : 0;
    sm = m_busy ? 7 - m_k : 7;
    w  = m_word;
    chk("lr_l", 32'(lr_l), 32'(m_lr()));
    chk("lr_m", 32'(lr_m), 32'(m_lr()));
    chk("bv_l", 32'(bv_l), 32'(m_busy));
    chk("bv_m", 32'(bv_m), 32'(m_busy));
    chk("last_l", 32'(last_l), 32'(m_busy && m_k == 7));
    chk("last_m", 32'(last_m), 32'(m_busy && m_k == 7));
    chk("done_l", 32'(done_l), 32'(m_done));
    chk("done_m", 32'(done_m), 32'(m_done));
    chk("d_l", 32'(d_l), 32'(w));
    chk("d_m", 32'(d_m), 32'(w));
    chk("sel_l", 32'(sel_l), 32'(sl));
    chk("sel_m", 32'(sel_m), 32'(sm));
    chk("bo_l", 32'(bo_l), 32'(w[sl]));
    chk("bo_m", 32'(bo_m), 32'(w[sm]));
  endtask

  // Drive inputs, then sample at the falling edge.
  task automatic apply(input logic r, input logic lv, input logic [7:0] ld, input logic br);
    rst = r; load_valid = lv; load_data = ld; bit_ready = br;
    @(negedge clk);
    model_check();
  endtask

  // Advance through the rising edge and update the model from the same inputs.
  task automatic fin();
    logic lx, bx, fx;
    lx = load_valid && m_lr();
    bx = m_busy && bit_ready;
    fx = bx && (m_k == 7);
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0; m_k = 0; m_word = 8'h00; m_done = 1'b0;
    end else begin
      m_done = fx;
      if (lx) begin
        m_word = load_data; m_busy = 1'b1; m_k = 0;
      end else if (fx) begin
        m_busy = 1'b0; m_k = 0;
      end else if (bx) begin
        m_k++;
      end
    end
    #1;
  endtask

  task automatic cyc(input logic lv, input logic [7:0] ld, input logic br);
    apply(1'b0, lv, ld, br);
    fin();
  endtask

  typedef struct {
    logic       lv;
    logic [7:0] ld;
    logic       br;
    logic       exp_lr;
    logic       exp_bv;
    logic       exp_last;
    logic       exp_done;
    logic [2:0] exp_sel;
    logic       exp_bo;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic bits_a5[8];
    int   bv_cnt;
    int   done_at[$];

    m_busy = 1'b0; m_k = 0; m_word = 8'h00; m_done = 1'b0;
    bits_a5 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // Word 8'hA5, LSB-first instance: load, 8 bits, done pulse, idle.
    tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    for (int k = 0; k < 8; k++) begin
      tbl[k+1] = '{1'b0, 8'h00, 1'b1, (k == 7), 1'b1, (k == 7), 1'b0, 3'(k), bits_a5[k]};
    end
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1};

    // Reset state and first cycle after release.
    apply(1'b1, 1'b1, 8'hFF, 1'b1);
    chk("rst_lr", 32'(lr_l), 32'd0);
    fin();
    apply(1'b1, 1'b1, 8'hFF, 1'b1);
    fin();
    apply(1'b0, 1'b0, 8'h00, 1'b0);
    chk("post_rst_lr", 32'(lr_l), 32'd1);
    chk("post_rst_bv", 32'(bv_l), 32'd0);
    chk("post_rst_sel_m", 32'(sel_m), 32'd7);
    fin();

    for (int i = 0; i < 11; i++) begin
      apply(1'b0, tbl[i].lv, tbl[i].ld, tbl[i].br);
      chk($sformatf("tbl%0d_lr", i), 32'(lr_l), 32'(tbl[i].exp_lr));
      chk($sformatf("tbl%0d_bv", i), 32'(bv_l), 32'(tbl[i].exp_bv));
      chk($sformatf("tbl%0d_last", i), 32'(last_l), 32'(tbl[i].exp_last));
      chk($sformatf("tbl%0d_done", i), 32'(done_l), 32'(tbl[i].exp_done));
      chk($sformatf("tbl%0d_sel", i), 32'(sel_l), 32'(tbl[i].exp_sel));
      if (tbl[i].exp_bv) chk($sformatf("tbl%0d_bo", i), 32'(bo_l), 32'(tbl[i].exp_bo));
      fin();
    end

    // MSB-first 8'h80: one at sel 7, then zeros, last at sel 0.
    cyc(1'b1, 8'h80, 1'b1);
    apply(1'b0, 8'h00, 1'b0 | 1'b0, 1'b1);
    chk("msb80_first_sel", 32'(sel_m), 32'd7);
    chk("msb80_first_bo", 32'(bo_m), 32'd1);
    fin();
    for (int k = 1; k < 8; k++) begin
      apply(1'b0, 1'b0, 8'h00, 1'b1);
      chk("msb80_bo", 32'(bo_m), 32'd0);
      if (k == 7) begin
        chk("msb80_last", 32'(last_m), 32'd1);
        chk("msb80_last_sel", 32'(sel_m), 32'd0);
      end
      fin();
    end
    cyc(1'b0, 8'h00, 1'b1);

    // 8'hF0 stalled at sel 3 for three cycles.
    cyc(1'b1, 8'hF0, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b0, 8'h00, 1'b0);
      chk("stall_sel", 32'(sel_l), 32'd3);
      chk("stall_bo", 32'(bo_l), 32'd0);
      fin();
    end
    apply(1'b0, 1'b0, 8'h00, 1'b1);
    chk("resume_sel3", 32'(sel_l), 32'd3);
    fin();
    apply(1'b0, 1'b0, 8'h00, 1'b1);
    chk("resume_sel4", 32'(sel_l), 32'd4);
    chk("resume_bo4", 32'(bo_l), 32'd1);
    fin();
    for (int k = 0; k < 4; k++) cyc(1'b0, 8'h00, 1'b1);

    // Back-to-back 8'h3C then 8'hC3 with load_valid held.
    cyc(1'b1, 8'h3C, 1'b1);
    bv_cnt = 0;
    for (int i = 0; i < 18; i++) begin
      apply(1'b0, (i < 8), 8'hC3, 1'b1);
      if (i < 16 && bv_l) bv_cnt++;
      if (done_l) done_at.push_back(i);
      fin();
    end
    chk("b2b_bv_cnt", 32'(bv_cnt), 32'd16);
    chk("b2b_done_cnt", 32'(done_at.size()), 32'd2);
    if (done_at.size() == 2) begin
      chk("b2b_done0", 32'(done_at[0]), 32'd8);
      chk("b2b_done_gap", 32'(done_at[1] - done_at[0]), 32'd8);
    end

    // Load offered mid-word is ignored.
    cyc(1'b1, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    apply(1'b0, 1'b1, 8'hFF, 1'b1);
    chk("midload_sel", 32'(sel_l), 32'd2);
    chk("midload_lr", 32'(lr_l), 32'd0);
    fin();
    apply(1'b0, 1'b0, 8'h00, 1'b1);
    chk("midload_d", 32'(d_l), 32'd0);
    fin();
    for (int k = 0; k < 5; k++) cyc(1'b0, 8'h00, 1'b1);

    // Reset mid-word at sel 4.
    cyc(1'b1, 8'h5A, 1'b1);
    for (int k = 0; k < 4; k++) cyc(1'b0, 8'h00, 1'b1);
    apply(1'b1, 1'b0, 8'h00, 1'b1);
    chk("midrst_sel", 32'(sel_l), 32'd4);
    chk("midrst_lr", 32'(lr_l), 32'd0);
    fin();
    apply(1'b0, 1'b0, 8'h00, 1'b1);
    chk("midrst_bv", 32'(bv_l), 32'd0);
    chk("midrst_sel0", 32'(sel_l), 32'd0);
    chk("midrst_d", 32'(d_l), 32'd0);
    chk("midrst_done", 32'(done_l), 32'd0);
    chk("midrst_lr1", 32'(lr_l), 32'd1);
    fin();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(0, 59) == 0), 1'($urandom), 8'($urandom),
            ($urandom_range(0, 3) != 0));
      fin();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
